// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the multi-cycle serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Slice counter width; never below one bit so N=1 still has a legal counter.
  function automatic int unsigned cnt_w(input int unsigned width, input int unsigned step);
    int unsigned n;
    n = width / step;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sub_slice.sv
// Combinational STEP-bit ripple subtractor built from 1-bit full-subtract cells.
module sub_slice #(
  parameter int unsigned STEP = 1
) (
  input  logic [STEP-1:0] a,
  input  logic [STEP-1:0] b,
  input  logic            bin,
  output logic [STEP-1:0] d,
  output logic            bout
);

  logic [STEP:0] br;

  assign br[0] = bin;

  for (genvar i = 0; i < STEP; i++) begin : g_cell
    assign d[i]    = a[i] ^ b[i] ^ br[i];
    assign br[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
  end

  assign bout = br[STEP];

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle unsigned a - b - bin, STEP bits per clock with a registered borrow.
// Optional feature: SERIAL_SUB_SAT_EN saturates diff to zero on final borrow.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int unsigned N  = WIDTH / STEP;
  localparam int unsigned CW = cnt_w(WIDTH, STEP);

  if (WIDTH < 1 || STEP < 1 || (WIDTH % STEP) != 0) begin : g_param_err
    $error("serial_subtractor: WIDTH must be >= 1 and a multiple of STEP");
  end

  state_t               state, state_d;
  logic [WIDTH-1:0]     a_sh, b_sh, res;
  logic                 borrow;
  logic [CW-1:0]        cnt;
  logic [STEP-1:0]      sd;
  logic                 sb;
  logic [WIDTH+STEP-1:0] res_cat;
  logic [WIDTH-1:0]     res_nx;
  logic                 accept, last;
  logic                 unused_bits;

  sub_slice #(.STEP(STEP)) u_slice (
    .a    (a_sh[STEP-1:0]),
    .b    (b_sh[STEP-1:0]),
    .bin  (borrow),
    .d    (sd),
    .bout (sb)
  );

  // Slice result enters from the MSB side; the dropped low bits are the old LSBs.
  assign res_cat     = {sd, res};
  assign res_nx      = res_cat[WIDTH+STEP-1:STEP];
  assign unused_bits = ^res_cat[STEP-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    last    = (state == RUN) && (cnt == CW'(N - 1));
    case (state)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res    <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
    end else begin
      busy <= (state_d == RUN);
      done <= (state_d == DONE);
      if (accept) begin
        a_sh   <= a;
        b_sh   <= b;
        borrow <= bin;
        res    <= '0;
        cnt    <= '0;
      end else if (state == RUN) begin
        a_sh   <= a_sh >> STEP;
        b_sh   <= b_sh >> STEP;
        res    <= res_nx;
        borrow <= sb;
        cnt    <= cnt + CW'(1);
        if (last) begin
`ifdef SERIAL_SUB_SAT_EN
          diff <= sb ? '0 : res_nx;
`else
          diff <= res_nx;
`endif
          bout <= sb;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (8/1, 16/4 and 8/8 builds).
module tb_serial_subtractor;

`ifdef SERIAL_SUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;

  logic       start8, bin8, busy8, done8, bout8;
  logic [7:0] a8, b8, diff8;
  logic        start16, bin16, busy16, done16, bout16;
  logic [15:0] a16, b16, diff16;
  logic       start1, bin1, busy1, done1, bout1;
  logic [7:0] a1, b1, diff1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8), .STEP(1)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
  );

  serial_subtractor #(.WIDTH(16), .STEP(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .bin(bin16),
    .busy(busy16), .done(done16), .diff(diff16), .bout(bout16)
  );

  serial_subtractor #(.WIDTH(8), .STEP(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present operands with start for one edge; returns just after the accepting edge.
  task automatic start_op8(input logic [7:0] a, input logic [7:0] b, input logic bin);
    a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
  endtask

  // Wait (bounded) for done, then check latency, busy profile and result.
  task automatic wait_op8(input string tag, input logic [7:0] exp_d, input logic exp_bo);
    int cyc = 0;
    int busy_cnt = 0;
    while (!done8 && cyc < 40) begin
      if (busy8) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
    check({tag, "_lat"}, 32'(cyc), 32'd8);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd8);
    check({tag, "_busy_in_done"}, 32'(busy8), 32'd0);
    check({tag, "_diff"}, 32'(diff8), 32'(exp_d));
    check({tag, "_bout"}, 32'(exp_bo ? 1 : 0), 32'(bout8));
  endtask

  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic bin, input logic [7:0] exp_d, input logic exp_bo);
    @(negedge clk);
    start_op8(a, b, bin);
    wait_op8(tag, exp_d, exp_bo);
  endtask

  initial begin
    int cyc;
    int done_seen;
    rst_n = 1'b0;
    start8 = 0; a8 = '0; b8 = '0; bin8 = 0;
    start16 = 0; a16 = '0; b16 = '0; bin16 = 0;
    start1 = 0; a1 = '0; b1 = '0; bin1 = 0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_diff", 32'(diff8), 32'd0);
    check("rst_bout", 32'(bout8), 32'd0);
    rst_n = 1'b1;

    run8("nominal", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0);
    run8("underflow", 8'h00, 8'h01, 1'b0, SAT ? 8'h00 : 8'hFF, 1'b1);
    run8("bin_zero", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0);
    run8("bin_under", 8'h10, 8'h10, 1'b1, SAT ? 8'h00 : 8'hFF, 1'b1);
    run8("ff_minus_1", 8'hFF, 8'h01, 1'b0, 8'hFE, 1'b0);
    run8("msb_cross", 8'h80, 8'h7F, 1'b0, 8'h01, 1'b0);

    // Start pulsed mid-run with other operands must be ignored, with no queuing.
    @(negedge clk);
    start_op8(8'h33, 8'h11, 1'b0);
    a8 = 8'hAA; b8 = 8'h55; bin8 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    cyc = 3;
    while (!done8 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("ignore_lat", 32'(cyc), 32'd8);
    check("ignore_diff", 32'(diff8), 32'h22);
    @(negedge clk);
    check("ignore_noqueue_busy", 32'(busy8), 32'd0);
    check("ignore_noqueue_done", 32'(done8), 32'd0);

    // Back-to-back: start during the done cycle.
    run8("b2b_first", 8'h40, 8'h01, 1'b0, 8'h3F, 1'b0);
    start_op8(8'h02, 8'h03, 1'b0);
    check("b2b_busy", 32'(busy8), 32'd1);
    check("b2b_done_low", 32'(done8), 32'd0);
    wait_op8("b2b_second", SAT ? 8'h00 : 8'hFF, 1'b1);

    // Reset during the third run cycle aborts the operation.
    @(negedge clk);
    start_op8(8'h5A, 8'h3C, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy8), 32'd0);
    check("midrst_done", 32'(done8), 32'd0);
    check("midrst_diff", 32'(diff8), 32'd0);
    check("midrst_bout", 32'(bout8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done8) done_seen++;
    end
    check("midrst_no_done", 32'(done_seen), 32'd0);
    run8("after_rst", 8'hC8, 8'h64, 1'b0, 8'h64, 1'b0);

    // WIDTH=16, STEP=4: four run cycles.
    @(negedge clk);
    a16 = 16'h1234; b16 = 16'h0FFF; bin16 = 1'b0; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    cyc = 0;
    while (!done16 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("w16_lat", 32'(cyc), 32'd4);
    check("w16_diff", 32'(diff16), 32'h0235);
    check("w16_bout", 32'(bout16), 32'd0);

    // STEP == WIDTH: single run cycle.
    @(negedge clk);
    a1 = 8'h01; b1 = 8'h02; bin1 = 1'b0; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check("n1_busy", 32'(busy1), 32'd1);
    cyc = 0;
    while (!done1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("n1_lat", 32'(cyc), 32'd1);
    check("n1_diff", 32'(diff1), SAT ? 32'h00 : 32'hFF);
    check("n1_bout", 32'(bout1), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
